// File: rtl/cpu_idecode_unit.sv
// RAPID ID stage: RV32I decode into one output item register, load-use stall, IF redirect handshake.
// Optional build macro ID_ILLEGAL_INSN_EN: pass unknown encodings to EX flagged as illegal instead of dropping them.
module cpu_idecode_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [XLEN-1:0] i_if_insn,
  output logic            o_if_ready,
  output logic            o_if_pc_load,
  output logic [XLEN-1:0] o_if_ext_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_ex_ready,
  input  logic            i_ex_load_valid,
  input  logic [4:0]      i_ex_load_rd,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_insn,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_class,
  output logic            o_illegal
);

  typedef enum logic [0:0] {S_IDLE, S_PENDING} redir_state_e;
  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_SYSTEM, CL_FENCE
  } insn_class_e;

  redir_state_e    state, state_nx;
  logic [XLEN-1:0] target;
  logic            full;

  logic [31:0]     insn;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm;
  insn_class_e     d_class;
  logic            d_known, d_illegal, presented;
  logic            hazard, fire, space;
  logic            capture, clear, load_target;

  assign insn = i_if_insn[31:0];

  always_comb begin
    d_rs1   = insn[19:15];
    d_rs2   = '0;
    d_rd    = insn[11:7];
    d_imm   = '0;
    d_class = CL_SYSTEM;
    d_known = 1'b1;
    case (insn[6:0])
      7'b0110011: begin d_class = CL_ALU_R; d_rs2 = insn[24:20]; end
      7'b0010011: begin d_class = CL_ALU_I; d_imm = {{(XLEN-12){insn[31]}}, insn[31:20]}; end
      7'b0000011: begin d_class = CL_LOAD;  d_imm = {{(XLEN-12){insn[31]}}, insn[31:20]}; end
      7'b1100111: begin d_class = CL_JALR;  d_imm = {{(XLEN-12){insn[31]}}, insn[31:20]}; end
      7'b0100011: begin
        d_class = CL_STORE; d_rs2 = insn[24:20]; d_rd = '0;
        d_imm   = {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
      end
      7'b1100011: begin
        d_class = CL_BRANCH; d_rs2 = insn[24:20]; d_rd = '0;
        d_imm   = {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      7'b1101111: begin
        d_class = CL_JAL; d_rs1 = '0;
        d_imm   = {{(XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      7'b0110111: begin d_class = CL_LUI;   d_rs1 = '0; d_imm = {{(XLEN-32){insn[31]}}, insn[31:12], 12'b0}; end
      7'b0010111: begin d_class = CL_AUIPC; d_rs1 = '0; d_imm = {{(XLEN-32){insn[31]}}, insn[31:12], 12'b0}; end
      7'b1110011: d_class = CL_SYSTEM;
      7'b0001111: d_class = CL_FENCE;
      default: begin
        d_known = 1'b0;
        d_rs1   = '0;
        d_rd    = '0;
      end
    endcase
  end

`ifdef ID_ILLEGAL_INSN_EN
  assign presented = (i_if_insn != NOP_INSN);
  assign d_illegal = !d_known;
`else
  assign presented = (i_if_insn != NOP_INSN) && d_known;
  assign d_illegal = 1'b0;
`endif

  // rs2 is zeroed when unused and load_rd==0 never hazards, so a plain compare covers "rs2 used"
  assign hazard     = full && i_ex_load_valid && (i_ex_load_rd != '0) &&
                      ((i_ex_load_rd == o_rs1) || (i_ex_load_rd == o_rs2));
  assign o_valid    = full && !hazard;
  assign fire       = o_valid && i_ex_ready;
  assign space      = !full || fire;
  assign o_if_ready = space || (state == S_PENDING);

  always_comb begin
    state_nx     = state;
    o_if_pc_load = 1'b0;
    o_if_ext_pc  = '0;
    capture      = 1'b0;
    clear        = 1'b0;
    load_target  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_redirect) begin
          clear       = 1'b1;
          load_target = 1'b1;
          if (presented) begin
            o_if_pc_load = 1'b1;
            o_if_ext_pc  = i_redirect_pc;
          end else begin
            state_nx = S_PENDING;
          end
        end else if (space && presented) begin
          capture = 1'b1;
        end
      end
      S_PENDING: begin
        o_if_pc_load = 1'b1;
        o_if_ext_pc  = target;
        if (i_redirect) begin
          clear       = 1'b1;
          load_target = 1'b1;
        end else if (presented) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      target <= '0;
    end else begin
      state <= state_nx;
      if (load_target) target <= i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      full       <= 1'b0;
      o_pc       <= '0;
      o_insn     <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
      o_rd       <= '0;
      o_funct3   <= '0;
      o_funct7b5 <= 1'b0;
      o_imm      <= '0;
      o_class    <= '0;
      o_illegal  <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (capture) begin
      full       <= 1'b1;
      o_pc       <= i_if_pc;
      o_insn     <= i_if_insn;
      o_rs1      <= d_rs1;
      o_rs2      <= d_rs2;
      o_rd       <= d_rd;
      o_funct3   <= insn[14:12];
      o_funct7b5 <= insn[30];
      o_imm      <= d_imm;
      o_class    <= d_class;
      o_illegal  <= d_illegal;
    end else if (fire) begin
      full <= 1'b0;
    end
  end

endmodule
